// File: rtl/master_alu_pkg.sv
// Shared types for the master_alu execute-stage ALU: opcode and condition
// encodings plus NZCV flag bit positions.
package master_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_XOR = 4'b0101,
        OP_MVN = 4'b0110,
        OP_MOV = 4'b0111,
        OP_LSR = 4'b1000,
        OP_LSL = 4'b1001,
        OP_ROR = 4'b1010,
        OP_CMP = 4'b1011,
        OP_ADR = 4'b1100,
        OP_LDR = 4'b1101,
        OP_STR = 4'b1110,
        OP_NOP = 4'b1111
    } opcode_e;

    typedef enum logic [3:0] {
        COND_AL = 4'b0000,
        COND_EQ = 4'b0001,
        COND_NE = 4'b0010,
        COND_CS = 4'b0011,
        COND_CC = 4'b0100,
        COND_MI = 4'b0101,
        COND_PL = 4'b0110,
        COND_VS = 4'b0111,
        COND_VC = 4'b1000,
        COND_HI = 4'b1001,
        COND_LS = 4'b1010,
        COND_GE = 4'b1011,
        COND_LT = 4'b1100,
        COND_GT = 4'b1101,
        COND_LE = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational condition-code evaluator: decides whether an instruction
// executes given its 4-bit condition and the current NZCV flags.
module alu_cond_check
    import master_alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flag[FLAG_N];
    assign z = flag[FLAG_Z];
    assign c = flag[FLAG_C];
    assign v = flag[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/master_alu.sv
// Registered 32-bit conditional ALU with NZCV flag generation.
// Optional multiplier enabled by defining ALU_MUL_EN; otherwise MUL acts as NOP.
module master_alu
    import master_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [IMM_W-1:0] iv,
    input  logic [3:0]       opcode,
    input  logic [3:0]       cond,
    input  logic             s,
    output logic [WIDTH-1:0] result,
    input  logic [3:0]       flag,
    output logic [3:0]       new_flag
);

    logic [WIDTH-1:0] op2;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf, sub_ovf;
    logic [4:0]       amt;
    logic [WIDTH-1:0] ror_val;
    logic             lsr_c, lsl_c;
    logic             cond_pass;
    opcode_e          op_e;

    logic [WIDTH-1:0] calc;
    logic             c_out, v_out;
    logic             wr_result, wr_flag;

    logic [WIDTH-1:0] result_reg;
    logic [3:0]       new_flag_reg;

    assign op_e = opcode_e'(opcode);
    assign op2  = (iv != '0) ? {{(WIDTH-IMM_W){1'b0}}, iv} : reg2;

    assign sum     = {1'b0, reg1} + {1'b0, op2};
    assign diff    = {1'b0, reg1} - {1'b0, op2};
    assign add_ovf = (reg1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
    assign sub_ovf = (reg1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);

    // Shift carries: last bit shifted out. 5-bit wrap makes 0-amt == 32-amt.
    assign amt     = op2[4:0];
    assign ror_val = (reg1 >> amt) | (reg1 << (6'd32 - {1'b0, amt}));
    assign lsr_c   = reg1[amt - 5'd1];
    assign lsl_c   = reg1[5'd0 - amt];

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mul_val;
    assign mul_val = $signed(reg1) * $signed(op2);
`endif

    alu_cond_check u_cond_check (
        .cond (cond),
        .flag (flag),
        .pass (cond_pass)
    );

    always_comb begin
        calc      = '0;
        c_out     = flag[FLAG_C];
        v_out     = flag[FLAG_V];
        wr_result = 1'b0;
        wr_flag   = 1'b0;
        case (op_e)
            OP_ADD, OP_ADR, OP_LDR, OP_STR: begin
                calc = sum[WIDTH-1:0]; c_out = sum[WIDTH]; v_out = add_ovf;
                wr_result = 1'b1; wr_flag = 1'b1;
            end
            OP_SUB: begin
                calc = diff[WIDTH-1:0]; c_out = ~diff[WIDTH]; v_out = sub_ovf;
                wr_result = 1'b1; wr_flag = 1'b1;
            end
            OP_CMP: begin
                calc = diff[WIDTH-1:0]; c_out = ~diff[WIDTH]; v_out = sub_ovf;
                wr_flag = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                calc = mul_val; wr_result = 1'b1; wr_flag = 1'b1;
            end
`endif
            OP_OR:  begin calc = reg1 | op2; wr_result = 1'b1; wr_flag = 1'b1; end
            OP_AND: begin calc = reg1 & op2; wr_result = 1'b1; wr_flag = 1'b1; end
            OP_XOR: begin calc = reg1 ^ op2; wr_result = 1'b1; wr_flag = 1'b1; end
            OP_MVN: begin calc = ~op2;       wr_result = 1'b1; wr_flag = 1'b1; end
            OP_MOV: begin calc = op2;        wr_result = 1'b1; wr_flag = 1'b1; end
            OP_LSR: begin
                calc = reg1 >> amt;
                if (amt != 5'd0) c_out = lsr_c;
                wr_result = 1'b1; wr_flag = 1'b1;
            end
            OP_LSL: begin
                calc = reg1 << amt;
                if (amt != 5'd0) c_out = lsl_c;
                wr_result = 1'b1; wr_flag = 1'b1;
            end
            OP_ROR: begin
                calc = ror_val;
                if (amt != 5'd0) c_out = ror_val[WIDTH-1];
                wr_result = 1'b1; wr_flag = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg   <= '0;
            new_flag_reg <= '0;
        end else begin
            if (cond_pass && wr_result)
                result_reg <= calc;
            if (cond_pass && wr_flag && (s || op_e == OP_CMP))
                new_flag_reg <= {calc[WIDTH-1], (calc == '0), c_out, v_out};
            else
                new_flag_reg <= flag;
        end
    end

    assign result   = result_reg;
    assign new_flag = new_flag_reg;

endmodule

// File: tb/tb_master_alu.sv
// Self-checking bench for master_alu: directed cases from the plan, then
// randomized operations against an arithmetic reference model.
module tb_master_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg1, reg2;
    logic [15:0] iv;
    logic [3:0]  opcode, cond, flag;
    logic        s;
    logic [31:0] result;
    logic [3:0]  new_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_result;
    logic [3:0]  m_flag;

    master_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg1     (reg1),
        .reg2     (reg2),
        .iv       (iv),
        .opcode   (opcode),
        .cond     (cond),
        .s        (s),
        .result   (result),
        .flag     (flag),
        .new_flag (new_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        case (cc)
            4'd0:  return 1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return c;
            4'd4:  return !c;
            4'd5:  return n;
            4'd6:  return !n;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return c && !z;
            4'd10: return !c || z;
            4'd11: return n == v;
            4'd12: return n != v;
            4'd13: return !z && (n == v);
            4'd14: return z || (n != v);
            default: return 0;
        endcase
    endfunction

    // Reference model: plain 64-bit integer arithmetic and a bitwise rotate loop.
    task automatic model_step();
        longint unsigned ua, ub, us;
        longint sa, sb, sr;
        logic [31:0] b, val;
        int sh;
        bit c, v, writes, flags;
        b = (iv != 0) ? {16'h0, iv} : reg2;
        ua = longint'(reg1) & 64'hFFFF_FFFF;
        ub = longint'(b) & 64'hFFFF_FFFF;
        sa = longint'($signed(reg1));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        c = flag[1]; v = flag[0];
        writes = 1; flags = 1; val = 0;
        case (opcode)
            4'd0, 4'd12, 4'd13, 4'd14: begin
                us = ua + ub; val = us[31:0]; c = (us >= 64'h1_0000_0000);
                sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1, 4'd11: begin
                val = reg1 - b; c = (ua >= ub);
                sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                if (opcode == 4'd11) writes = 0;
            end
            4'd2: begin
`ifdef ALU_MUL_EN
                sr = sa * sb; val = sr[31:0];
`else
                writes = 0; flags = 0;
`endif
            end
            4'd3: val = reg1 | b;
            4'd4: val = reg1 & b;
            4'd5: val = reg1 ^ b;
            4'd6: val = ~b;
            4'd7: val = b;
            4'd8: begin val = reg1 >> sh; if (sh != 0) c = (reg1 >> (sh - 1)) & 1; end
            4'd9: begin val = reg1 << sh; if (sh != 0) c = (reg1 >> (32 - sh)) & 1; end
            4'd10: begin
                val = reg1;
                for (int k = 0; k < sh; k++) val = {val[0], val[31:1]};
                if (sh != 0) c = val[31];
            end
            default: begin writes = 0; flags = 0; end
        endcase
        if (cond_ok(cond, flag)) begin
            if (writes) m_result = val;
            if (flags && (s || opcode == 4'd11))
                m_flag = {val[31], (val == 0), c, v};
            else
                m_flag = flag;
        end else begin
            m_flag = flag;
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [3:0] cc, input logic ss,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [3:0] f, input string tag);
        opcode = op; cond = cc; s = ss; reg1 = a; reg2 = b; iv = imm; flag = f;
        @(posedge clk);
        #1;
        model_step();
        check_eq({tag, " result"}, result, m_result);
        check_eq({tag, " flags"}, {28'h0, new_flag}, {28'h0, m_flag});
    endtask

    initial begin
        rst_n = 1'b0; reg1 = 0; reg2 = 0; iv = 0; opcode = 4'hF; cond = 0; s = 0; flag = 0;
        m_result = 0; m_flag = 0;
        #3;
        check_eq("reset result", result, 32'h0);
        check_eq("reset flags", {28'h0, new_flag}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(4'd7, 4'd0, 1'b1, 32'd0, 32'hDEADBEEF, 16'h0, 4'b0000, "pre-reset mov");
        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #2; rst_n = 1'b0; #1;
        check_eq("async reset result", result, 32'h0);
        check_eq("async reset flags", {28'h0, new_flag}, 32'h0);
        m_result = 0; m_flag = 0;
        @(negedge clk); rst_n = 1'b1;

        do_op(4'd0, 4'd0, 1'b0, 32'd1, 32'd1, 16'h0, 4'b0000, "add 1+1");
        check_eq("add 1+1 const", result, 32'd2);
        do_op(4'd0, 4'd0, 1'b1, 32'h6000_0000, 32'h2000_0001, 16'h0, 4'b0000, "add ovf");
        check_eq("add ovf const", result, 32'h8000_0001);
        check_eq("add ovf flag const", {28'h0, new_flag}, 32'b1001);
        do_op(4'd1, 4'd0, 1'b1, 32'd5, 32'd7, 16'h0, 4'b0000, "sub neg");
        check_eq("sub neg const", result, 32'hFFFF_FFFE);
        check_eq("sub neg flag const", {28'h0, new_flag}, 32'b1000);
        do_op(4'd1, 4'd0, 1'b0, 32'd5, 32'd7, 16'h0, 4'b0110, "sub s0");
        check_eq("sub s0 flag const", {28'h0, new_flag}, 32'b0110);
        do_op(4'd2, 4'd1, 1'b1, 32'd7, 32'd7, 16'h0, 4'b0100, "mul eq pass");
`ifdef ALU_MUL_EN
        check_eq("mul const", result, 32'd49);
        check_eq("mul flag const", {28'h0, new_flag}, 32'b0000);
`else
        check_eq("mul-as-nop const", result, 32'hFFFF_FFFE);
        check_eq("mul-as-nop flag const", {28'h0, new_flag}, 32'b0100);
`endif
        do_op(4'd2, 4'd1, 1'b1, 32'd7, 32'd7, 16'h0, 4'b0000, "mul eq fail");
        check_eq("cond fail flag const", {28'h0, new_flag}, 32'b0000);
        do_op(4'd3, 4'd2, 1'b0, 32'd5, 32'd7, 16'h0, 4'b0000, "or ne");
        check_eq("or ne const", result, 32'd7);
        do_op(4'd5, 4'd0, 1'b0, 32'd5, 32'd70, 16'h0, 4'b0000, "xor");
        check_eq("xor const", result, 32'd67);
        do_op(4'd10, 4'd0, 1'b1, 32'd5, 32'd70, 16'h0, 4'b0000, "ror");
        check_eq("ror const", result, 32'h1400_0000);
        check_eq("ror flag const", {28'h0, new_flag}, 32'b0000);
        do_op(4'd9, 4'd0, 1'b0, 32'd5, 32'd7, 16'h0, 4'b0000, "lsl");
        check_eq("lsl const", result, 32'd640);
        do_op(4'd8, 4'd0, 1'b1, 32'd5, 32'd1, 16'h0, 4'b0000, "lsr");
        check_eq("lsr const", result, 32'd2);
        check_eq("lsr flag const", {28'h0, new_flag}, 32'b0010);
        do_op(4'd11, 4'd0, 1'b0, 32'd7, 32'd7, 16'h0, 4'b0000, "cmp");
        check_eq("cmp result const", result, 32'd2);
        check_eq("cmp flag const", {28'h0, new_flag}, 32'b0110);
        do_op(4'd15, 4'd0, 1'b1, 32'd9, 32'd9, 16'h0, 4'b1010, "nop");
        check_eq("nop result const", result, 32'd2);
        check_eq("nop flag const", {28'h0, new_flag}, 32'b1010);
        do_op(4'd7, 4'd0, 1'b0, 32'd0, 32'd7, 16'h00FF, 4'b0000, "mov imm");
        check_eq("mov imm const", result, 32'd255);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            logic [15:0] imm;
            logic [3:0]  cc;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            cc  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            do_op(4'($urandom), cc, 1'($urandom), a, b, imm, 4'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
